// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares one psram controller between the video line-fetch port (high
//   priority) and the command/CPU port (low priority). One transaction is in
//   flight at a time: IDLE arbitrates and latches the winner, ISSUE strobes the
//   controller, WAIT waits for done or timeout, DONE acks the winner.
//
//   Optional build macro: PSRAM_ARB_AGING_EN
//     defined   - after MAX_WAIT consecutive video grants taken while cmd was
//                 requesting, a contended cycle is given to cmd instead.
//     undefined - strict video priority, no aging counter.
//
//   Ports
//     i_clk, i_rstn           psram clock, synchronous active-low reset
//     i_vid_* / o_vid_*       video requester (req/we/addr/din, ack/err/rdata)
//     i_cmd_* / o_cmd_*       command requester, same shape as video
//     o_psram_stb/we/addr/din start strobe and latched request to controller
//     i_psram_busy/done/dout  controller status and read data
//     o_gnt                   current/last grant, 0=video 1=cmd
//     o_state                 FSM state (IDLE=0 ISSUE=1 WAIT=2 DONE=3)
//
//   Handshake: a requester raises req (level) with we/addr/din stable and
//   keeps it up until its ack. we/addr/din are captured only on the grant
//   cycle. ack is a one-cycle pulse; err is qualified by ack; rdata is valid
//   from the ack of a read and holds until that port's next read completes.
//   Dropping req before it is granted withdraws it without an ack.
module psram_arbiter #(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 16,
   parameter int TIMEOUT  = 255,
   parameter int MAX_WAIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_vid_req,
   input  logic              i_vid_we,
   input  logic [ADDR_W-1:0] i_vid_addr,
   input  logic [DATA_W-1:0] i_vid_din,
   output logic              o_vid_ack,
   output logic              o_vid_err,
   output logic [DATA_W-1:0] o_vid_rdata,
   input  logic              i_cmd_req,
   input  logic              i_cmd_we,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_din,
   output logic              o_cmd_ack,
   output logic              o_cmd_err,
   output logic [DATA_W-1:0] o_cmd_rdata,
   output logic              o_psram_stb,
   output logic              o_psram_we,
   output logic [ADDR_W-1:0] o_psram_addr,
   output logic [DATA_W-1:0] o_psram_din,
   input  logic              i_psram_busy,
   input  logic              i_psram_done,
   input  logic [DATA_W-1:0] i_psram_dout,
   output logic              o_gnt,
   output logic [1:0]        o_state
);

   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_inc;
   logic             timed_out;
   logic             err_q;
   logic             start;
   logic             pick_cmd;
   logic             cmd_first;

   // cmd wins when video is idle, or when aging says it has waited long enough.
   assign pick_cmd = i_cmd_req && (!i_vid_req || cmd_first);

`ifdef PSRAM_ARB_AGING_EN
   localparam int AGE_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MAX_WAIT);

   logic [AGE_W-1:0] age_cnt;

   assign cmd_first = (age_cnt == AGE_LAST);

   // Counts video grants taken while cmd was also asking; saturates.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         age_cnt <= '0;
      end else if (start) begin
         if (pick_cmd) begin
            age_cnt <= '0;
         end else if (i_cmd_req && (age_cnt != AGE_LAST)) begin
            age_cnt <= age_cnt + 1'b1;
         end
      end
   end
`else
   // Strict priority: cmd never jumps ahead of a requesting video port.
   assign cmd_first = (MAX_WAIT < 0);
`endif

   // Saturating increment; the abort fires on the cycle the count reaches
   // TIMEOUT, i.e. after exactly TIMEOUT cycles spent in WAIT without done.
   assign tmr_inc   = (tmr == TMR_LAST) ? tmr : tmr + 1'b1;
   assign timed_out = (tmr_inc == TMR_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (!i_psram_busy && (i_vid_req || i_cmd_req)) begin
               start     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (i_psram_done || timed_out) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_gnt        <= 1'b0;
         o_psram_we   <= 1'b0;
         o_psram_addr <= '0;
         o_psram_din  <= '0;
         o_vid_rdata  <= '0;
         o_cmd_rdata  <= '0;
         tmr          <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  o_gnt        <= pick_cmd;
                  o_psram_we   <= pick_cmd ? i_cmd_we   : i_vid_we;
                  o_psram_addr <= pick_cmd ? i_cmd_addr : i_vid_addr;
                  o_psram_din  <= pick_cmd ? i_cmd_din  : i_vid_din;
               end
            end
            ISSUE: begin
               tmr <= '0;
            end
            WAIT: begin
               if (i_psram_done) begin
                  err_q <= 1'b0;
                  if (!o_psram_we) begin
                     if (o_gnt) o_cmd_rdata <= i_psram_dout;
                     else       o_vid_rdata <= i_psram_dout;
                  end
               end else begin
                  tmr <= tmr_inc;
                  if (timed_out) err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Ack/err are decoded from the DONE state so a reset abandons them cleanly.
   assign o_psram_stb = (state == ISSUE);
   assign o_vid_ack   = (state == DONE) && !o_gnt;
   assign o_cmd_ack   = (state == DONE) &&  o_gnt;
   assign o_vid_err   = o_vid_ack && err_q;
   assign o_cmd_err   = o_cmd_ack && err_q;
   assign o_state     = state;

endmodule

// File: tb/tb_psram_arbiter.sv
module tb_psram_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam int W      = DATA_W + 3;

   logic              i_clk;
   logic              i_rstn;
   logic              i_vid_req, i_vid_we;
   logic [ADDR_W-1:0] i_vid_addr;
   logic [DATA_W-1:0] i_vid_din;
   logic              o_vid_ack, o_vid_err;
   logic [DATA_W-1:0] o_vid_rdata;
   logic              i_cmd_req, i_cmd_we;
   logic [ADDR_W-1:0] i_cmd_addr;
   logic [DATA_W-1:0] i_cmd_din;
   logic              o_cmd_ack, o_cmd_err;
   logic [DATA_W-1:0] o_cmd_rdata;
   logic              o_psram_stb, o_psram_we;
   logic [ADDR_W-1:0] o_psram_addr;
   logic [DATA_W-1:0] o_psram_din;
   logic              i_psram_busy, i_psram_done;
   logic [DATA_W-1:0] i_psram_dout;
   logic              o_gnt;
   logic [1:0]        o_state;

   // Expected acks in order: {cmd_ack, vid_ack, err, rdata of acked port}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs;
   int           n_cmp = 0;
   int           n_mis = 0;

   psram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .MAX_WAIT(2)
   ) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_vid_req(i_vid_req), .i_vid_we(i_vid_we), .i_vid_addr(i_vid_addr),
      .i_vid_din(i_vid_din), .o_vid_ack(o_vid_ack), .o_vid_err(o_vid_err),
      .o_vid_rdata(o_vid_rdata),
      .i_cmd_req(i_cmd_req), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
      .i_cmd_din(i_cmd_din), .o_cmd_ack(o_cmd_ack), .o_cmd_err(o_cmd_err),
      .o_cmd_rdata(o_cmd_rdata),
      .o_psram_stb(o_psram_stb), .o_psram_we(o_psram_we),
      .o_psram_addr(o_psram_addr), .o_psram_din(o_psram_din),
      .i_psram_busy(i_psram_busy), .i_psram_done(i_psram_done),
      .i_psram_dout(i_psram_dout), .o_gnt(o_gnt), .o_state(o_state)
   );

   // ---------------- clock / reset ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Scoreboard: every ack pulse must match the head of exp_q.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (o_vid_ack || o_cmd_ack) begin
            obs = {o_cmd_ack, o_vid_ack, (o_cmd_ack ? o_cmd_err : o_vid_err),
                   (o_cmd_ack ? o_cmd_rdata : o_vid_rdata)};
            if (exp_q.size() == 0) check("ack_unexpected", 32'(obs), 32'h0);
            else                   check("ack", 32'(obs), 32'(exp_q.pop_front()));
         end else if (o_vid_err || o_cmd_err) begin
            check("err_without_ack", {30'h0, o_cmd_err, o_vid_err}, 32'h0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_stb(input int max_cyc, output int cyc);
      cyc = 0;
      while (o_psram_stb !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
      check("stb_seen", {31'h0, o_psram_stb}, 32'h1);
   endtask

   // Called in the stb cycle; raises done lat cycles after stb, returns in DONE.
   task automatic serve(input int lat, input logic [DATA_W-1:0] dout, input logic we,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
      tick();
      check("stb_one_cycle", {31'h0, o_psram_stb}, 32'h0);
      check("in_wait", {30'h0, o_state}, 32'h2);
      for (int i = 1; i < lat; i++) tick();
      check("hold_we", {31'h0, o_psram_we}, {31'h0, we});
      check("hold_addr", 32'(o_psram_addr), 32'(addr));
      check("hold_din", 32'(o_psram_din), 32'(din));
      i_psram_done = 1'b1;
      i_psram_dout = dout;
      tick();
      i_psram_done = 1'b0;
      i_psram_dout = '0;
      check("in_done", {30'h0, o_state}, 32'h3);
   endtask

   task automatic xact(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] din, input int lat,
                       input logic [DATA_W-1:0] dout, input logic [W-1:0] exp);
      int cyc;
      if (port) begin
         i_cmd_we = we; i_cmd_addr = addr; i_cmd_din = din; i_cmd_req = 1'b1;
      end else begin
         i_vid_we = we; i_vid_addr = addr; i_vid_din = din; i_vid_req = 1'b1;
      end
      exp_q.push_back(exp);
      wait_stb(20, cyc);
      check("stb_latency", cyc, 1);
      check("gnt", {31'h0, o_gnt}, {31'h0, port});
      // Requester inputs changing after grant must not reach the controller.
      if (port) begin
         i_cmd_we = ~we; i_cmd_addr = ~addr; i_cmd_din = ~din;
      end else begin
         i_vid_we = ~we; i_vid_addr = ~addr; i_vid_din = ~din;
      end
      serve(lat, dout, we, addr, din);
      if (port) i_cmd_req = 1'b0;
      else      i_vid_req = 1'b0;
      tick();
      check("back_idle", {30'h0, o_state}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         cyc;
      int         stb_cnt;
      logic [5:0] order;

      i_rstn = 1'b0;
      i_vid_req = 1'b0; i_vid_we = 1'b0; i_vid_addr = '0; i_vid_din = '0;
      i_cmd_req = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_din = '0;
      i_psram_busy = 1'b0; i_psram_done = 1'b0; i_psram_dout = '0;
      repeat (3) tick();

      // Reset state
      check("rst_state", {30'h0, o_state}, 32'h0);
      check("rst_stb", {31'h0, o_psram_stb}, 32'h0);
      check("rst_acks", {28'h0, o_vid_ack, o_vid_err, o_cmd_ack, o_cmd_err}, 32'h0);
      check("rst_rdata", {o_vid_rdata, o_cmd_rdata}, 32'h0);
      check("rst_psram", {7'h0, o_gnt, o_psram_we, o_psram_addr}, 32'h0);
      check("rst_din", 32'(o_psram_din), 32'h0);
      i_rstn = 1'b1;

      // Idle for 100 cycles: no strobe
      stb_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_psram_stb) stb_cnt++;
      end
      check("idle_no_stb", stb_cnt, 0);

      // Command write, done 5 cycles after stb; rdata untouched
      xact(1'b1, 1'b1, 24'h000123, 16'hBEEF, 5, 16'hDEAD, {3'b100, 16'h0000});

      // Video read, rdata held afterwards
      xact(1'b0, 1'b0, 24'h000040, 16'h0000, 3, 16'h1234, {3'b010, 16'h1234});
      repeat ($urandom_range(1, 4)) tick();
      check("vid_rdata_held", 32'(o_vid_rdata), 32'h1234);

      // Command read must not disturb video rdata
      xact(1'b1, 1'b0, 24'h000080, 16'h0000, 2, 16'hA5A5, {3'b100, 16'hA5A5});
      check("vid_rdata_kept", 32'(o_vid_rdata), 32'h1234);

      // Simultaneous requests: video first, then cmd
      i_vid_we = 1'b0; i_vid_addr = 24'h000010; i_vid_din = '0;
      i_cmd_we = 1'b1; i_cmd_addr = 24'h000020; i_cmd_din = 16'h5A5A;
      i_vid_req = 1'b1; i_cmd_req = 1'b1;
      exp_q.push_back({3'b010, 16'h1111});
      exp_q.push_back({3'b100, 16'hA5A5});
      wait_stb(20, cyc);
      check("both_v_lat", cyc, 1);
      check("both_v_gnt", {31'h0, o_gnt}, 32'h0);
      serve(2, 16'h1111, 1'b0, 24'h000010, 16'h0000);
      i_vid_req = 1'b0;
      wait_stb(20, cyc);
      check("both_c_lat", cyc, 2);
      check("both_c_gnt", {31'h0, o_gnt}, 32'h1);
      serve(2, 16'h2222, 1'b1, 24'h000020, 16'h5A5A);
      i_cmd_req = 1'b0;
      tick();
      check("both_idle", {30'h0, o_state}, 32'h0);

      // Timeout: no done, abort after 8 WAIT cycles with err, rdata kept
      i_vid_we = 1'b0; i_vid_addr = 24'h000050; i_vid_req = 1'b1;
      exp_q.push_back({3'b011, 16'h1111});
      wait_stb(20, cyc);
      for (int i = 1; i <= 8; i++) tick();
      check("to_last_wait", {30'h0, o_state}, 32'h2);
      tick();
      check("to_done", {30'h0, o_state}, 32'h3);
      check("to_err", {31'h0, o_vid_err}, 32'h1);
      i_vid_req = 1'b0;
      tick();
      check("to_idle", {30'h0, o_state}, 32'h0);

      // Next request after a timeout is served normally
      xact(1'b1, 1'b1, 24'h000090, 16'hC0DE, 1, 16'h0000, {3'b100, 16'hA5A5});

      // Busy holds off the grant; a stray done in IDLE is ignored
      i_psram_busy = 1'b1;
      i_vid_we = 1'b1; i_vid_addr = 24'h000060; i_vid_din = 16'h7777; i_vid_req = 1'b1;
      exp_q.push_back({3'b010, 16'h1111});
      i_psram_done = 1'b1; i_psram_dout = 16'hFFFF;
      stb_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         i_psram_done = 1'b0; i_psram_dout = '0;
         if (o_psram_stb) stb_cnt++;
      end
      check("busy_no_stb", stb_cnt, 0);
      check("busy_idle", {30'h0, o_state}, 32'h0);
      i_psram_busy = 1'b0;
      tick();
      check("busy_stb_next", {31'h0, o_psram_stb}, 32'h1);
      serve(3, 16'h3333, 1'b1, 24'h000060, 16'h7777);
      i_vid_req = 1'b0;
      tick();

      // Both held: aging decides grant order
`ifdef PSRAM_ARB_AGING_EN
      order = 6'b100100;
`else
      order = 6'b000000;
`endif
      i_vid_we = 1'b0; i_vid_addr = 24'h000030; i_vid_din = '0;
      i_cmd_we = 1'b0; i_cmd_addr = 24'h000031; i_cmd_din = '0;
      i_vid_req = 1'b1; i_cmd_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back({order[k], ~order[k], 1'b0, 16'h0100 + 16'(k)});
         wait_stb(20, cyc);
         check("age_lat", cyc, (k == 0) ? 1 : 2);
         check("age_gnt", {31'h0, o_gnt}, {31'h0, order[k]});
         serve(2, 16'h0100 + 16'(k), 1'b0, order[k] ? 24'h000031 : 24'h000030, 16'h0000);
      end
      i_vid_req = 1'b0; i_cmd_req = 1'b0;
      tick();
      check("age_idle", {30'h0, o_state}, 32'h0);

      // Reset during WAIT: no ack, all outputs cleared
      i_cmd_we = 1'b0; i_cmd_addr = 24'h000070; i_cmd_din = 16'h4444; i_cmd_req = 1'b1;
      wait_stb(20, cyc);
      tick();
      tick();
      check("mr_in_wait", {30'h0, o_state}, 32'h2);
      i_rstn = 1'b0; i_cmd_req = 1'b0;
      tick();
      i_rstn = 1'b1;
      check("mr_state", {30'h0, o_state}, 32'h0);
      check("mr_stb", {31'h0, o_psram_stb}, 32'h0);
      check("mr_psram", {7'h0, o_gnt, o_psram_we, o_psram_addr}, 32'h0);
      check("mr_din", 32'(o_psram_din), 32'h0);
      check("mr_rdata", {o_vid_rdata, o_cmd_rdata}, 32'h0);
      check("mr_acks", {28'h0, o_vid_ack, o_vid_err, o_cmd_ack, o_cmd_err}, 32'h0);
      i_psram_done = 1'b1; i_psram_dout = 16'h9999;
      tick();
      i_psram_done = 1'b0; i_psram_dout = '0;
      repeat (20) tick();
      check("mr_quiet_state", {30'h0, o_state}, 32'h0);
      check("mr_quiet_rdata", 32'(o_cmd_rdata), 32'h0);

      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
Shares the single psram controller between two requesters: the video line-fetch port (high priority) and the command/CPU port (low priority). It sequences one transaction at a time: arbitrate, latch the request, strobe the controller, wait for done or timeout, then return data and ack to the winner. It sits between the video/command logic and the psram instance, in the psram clock domain.

Parameters:
ADDR_W, 24, psram word address width
DATA_W, 16, data width
TIMEOUT, 255, max WAIT cycles before the transaction is aborted with error
MAX_WAIT, 4, consecutive video grants tolerated while cmd is pending (aging feature only)

Ports:
i_clk  in  1  clock (psram clock domain)
i_rstn  in  1  reset; synchronous and active-low
i_vid_req  in  1  video request, level; held until o_vid_ack
i_vid_we  in  1  video write enable (1=write)
i_vid_addr  in  ADDR_W  video address
i_vid_din  in  DATA_W  video write data
o_vid_ack  out  1  one-cycle completion pulse
o_vid_err  out  1  valid with o_vid_ack; 1=timed out
o_vid_rdata  out  DATA_W  read data; valid from o_vid_ack, held until next video read completes
i_cmd_req, i_cmd_we, i_cmd_addr, i_cmd_din, o_cmd_ack, o_cmd_err, o_cmd_rdata: same widths and semantics for the command port
o_psram_stb  out  1  one-cycle start strobe to the controller
o_psram_we  out  1  latched write enable
o_psram_addr  out  ADDR_W  latched address
o_psram_din  out  DATA_W  latched write data
i_psram_busy  in  1  controller busy
i_psram_done  in  1  controller one-cycle completion pulse
i_psram_dout  in  DATA_W  controller read data, valid with i_psram_done
o_gnt  out  1  current/last grant: 0=video, 1=cmd
o_state  out  2  FSM state, for debug display

Behaviour:
- Reset (i_rstn low at a clock edge): state IDLE. All outputs 0: acks, errs, rdata, stb, we, addr, din, gnt, o_state. Aging counter cleared.
- State encodings: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- IDLE:
  - If i_psram_busy=1 or no request: stay.
  - Else grant video if i_vid_req, else cmd if i_cmd_req.
  - Latch the winner's we/addr/din onto o_psram_*. Set o_gnt. Go to ISSUE.
- ISSUE: o_psram_stb=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On i_psram_done: if the latched we=0, load i_psram_dout into the granted port's rdata. Go to DONE with err=0.
  - Else increment the timer. When the timer reaches TIMEOUT, go to DONE with err=1 and leave rdata unchanged.
- DONE: pulse the granted port's ack (and err) for one cycle, then go to IDLE.
- Latency: request sampled in IDLE at cycle N, stb at N+1. Ack comes 1 cycle after the done cycle. Minimum request-to-request spacing is 4 cycles plus controller latency.
- o_psram_we/addr/din hold their latched values from ISSUE until the next grant. They never change while in WAIT.
- i_psram_done outside WAIT is ignored.
- Requester inputs are sampled only at grant. Changes after grant have no effect. Deasserting req before grant withdraws it with no ack.
- A requester's ack never pulses unless that requester was granted. Both acks are never high together.
- Simultaneous requests: video wins (strict priority), unless the aging feature overrides.
- Reset mid-transaction: return to IDLE, drop stb, and produce no ack for the abandoned transaction.
- Timer width: clog2(TIMEOUT+1). Counters saturate and never wrap.

Optional Feature:
PSRAM_ARB_AGING_EN
- Defined: a counter increments each time video is granted while i_cmd_req=1. When the counter equals MAX_WAIT and both ports request, cmd is granted. The counter clears on every cmd grant.
- Undefined: strict video priority, and no counter is instantiated.

Test Plan:
- Reset, then check outputs: all outputs 0 and o_state=0. With no requests, o_psram_stb stays 0 for 100 cycles.
- Command write, single port: cmd req, we=1, addr=0x000123, din=0xBEEF, with done 5 cycles after stb. Required: stb exactly 1 cycle, at the cycle after req is sampled. o_psram_addr=0x000123 and o_psram_din=0xBEEF held through WAIT. o_cmd_ack 1 cycle after done, o_cmd_err=0. o_cmd_rdata unchanged.
- Video read: vid req, we=0, addr=0x000040, done carrying dout=0x1234. Required: o_vid_rdata=0x1234 at the o_vid_ack cycle and held afterwards. o_gnt=0.
- Arbitration:
  - Both ports request in the same cycle: video is served first, then cmd.
  - With PSRAM_ARB_AGING_EN and MAX_WAIT=2, video held high and cmd held high: grant order is V,V,C,V,V,C.
- Timeout: TIMEOUT=8 and done never asserted. Required: ack with err=1 after 8 WAIT cycles, rdata unchanged, return to IDLE, and the next request is served normally.
- Busy and mid-transaction reset:
  - i_psram_busy=1 in IDLE with a request pending: no stb until busy falls, then stb on the next cycle.
  - i_rstn pulsed low during WAIT: no ack ever issued, and outputs are 0 on the cycle after reset.
